imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_ram.sv | 29 ++
 rtl/imem_responder.sv | 111 +++++++++++
 tb/tb_imem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory responder
package imem_pkg;

    localparam int XLEN            = 32;
    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x 32 storage, one synchronous write port, one registered read port
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = addr_bits(DEFAULT_DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Both ports sample the array before the edge, so a same-word write is not seen by this read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - single-outstanding instruction fetch responder with fixed latency
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    input  logic            prog_we,
    input  logic [XLEN-1:0] prog_addr,
    input  logic [XLEN-1:0] prog_wdata
);

    localparam int AW = addr_bits(DEPTH);

    state_t          state;
    state_t          state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] addr_q;
    logic            err_q;
    logic            accept;
    logic            fire;
    logic            ram_re;
    logic            fetch_misaligned;
    logic            fetch_out_of_range;
    logic            prog_in_range;
    logic [XLEN-1:0] ram_rdata;
    logic            unused_prog_lsbs;

    assign accept = req_valid && req_ready;
    assign fire   = (state == WAIT) && (cnt == '0);

    assign fetch_misaligned   = (addr_q[1:0] != 2'b00);
    assign fetch_out_of_range = ({2'b00, addr_q[XLEN-1:2]} >= 32'(DEPTH));
    assign prog_in_range      = ({2'b00, prog_addr[XLEN-1:2]} < 32'(DEPTH));
    assign unused_prog_lsbs   = ^prog_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (fire) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_re     = 1'b0;
        case (state)
            IDLE:    req_ready = !rst;
            WAIT:    ram_re = fire;
            RESP:    resp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                cnt    <= CNT_W'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (fire) begin
                err_q <= fetch_misaligned || fetch_out_of_range;
            end
        end
    end

    // Data is squashed outside RESP so an aborted or faulted fetch never exposes RAM contents.
    assign resp_err  = resp_valid && err_q;
    assign resp_data = (resp_valid && !err_q) ? ram_rdata : '0;

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we && prog_in_range),
        .waddr (prog_addr[AW+1:2]),
        .wdata (prog_wdata),
        .re    (ram_re),
        .raddr (addr_q[AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;
    import imem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: a request due LATENCY edges after acceptance, fetched from a shadow memory.
    logic [31:0] mmem [DEPTH];
    bit          m_pend = 0;
    bit          m_valid = 0;
    int          m_due = 0;
    int          edge_n = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_err = 0;
    bit          m_busy;
    bit          prev_valid = 0;
    int          rise_cyc[$];
    logic [31:0] rise_data[$];

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_pend  = 0;
            m_valid = 0;
        end else begin
            m_busy = m_pend || m_valid;
            if (m_valid && resp_ready) begin
                m_valid = 0;
            end else if (m_pend && edge_n == m_due) begin
                m_pend  = 0;
                m_valid = 1;
                m_err   = (m_addr[1:0] != 2'b00) || (m_addr[31:2] >= DEPTH);
                m_data  = m_err ? 32'h0 : mmem[m_addr[9:2]];
            end
            if (!m_busy && req_valid) begin
                m_pend = 1;
                m_due  = edge_n + LAT;
                m_addr = req_addr;
            end
        end
        if (prog_we && (prog_addr[31:2] < DEPTH)) begin
            mmem[prog_addr[9:2]] = prog_wdata;
        end
    end

    always @(negedge clk) begin
        chk("model_req_ready", req_ready, !rst && !(m_pend || m_valid));
        chk("model_resp_valid", resp_valid, m_valid && !rst);
        if (m_valid && !rst) begin
            chk("model_resp_data", resp_data, m_data);
            chk("model_resp_err", resp_err, m_err);
        end
        if (resp_valid && !prev_valid) begin
            rise_cyc.push_back(edge_n);
            rise_data.push_back(resp_data);
        end
        prev_valid = resp_valid;
    end

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_wdata = d;
        @(posedge clk); #2;
        prog_we = 1'b0;
    endtask

    // Called at 2 time units after a rising edge with the block idle.
    task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input logic ee,
                         input int hold, input string nm);
        int n;
        logic [31:0] held;
        #1;
        chk({nm, "_ready_before"}, req_ready, 1);
        req_valid = 1'b1;
        req_addr = a;
        resp_ready = 1'b0;
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFC;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk({nm, "_latency"}, n, LAT);
        chk({nm, "_data"}, resp_data, ed);
        chk({nm, "_err"}, resp_err, ee);
        held = resp_data;
        repeat (hold) begin
            @(posedge clk); #2;
            chk({nm, "_hold_valid"}, resp_valid, 1);
            chk({nm, "_hold_data"}, resp_data, held);
            chk({nm, "_hold_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #2;
        resp_ready = 1'b0;
        chk({nm, "_done_valid"}, resp_valid, 0);
        chk({nm, "_done_ready"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        prog(32'h0000_0000, 32'h1111_1111);
        prog(32'h0000_0004, 32'h0050_0093);
        prog(32'h0000_000B, 32'h00A0_0113);
        prog(32'h0000_000C, 32'h3333_3333);

        fetch(32'h0000_0004, 32'h0050_0093, 1'b0, 0, "load_fetch");
        fetch(32'h0000_0004, 32'h0050_0093, 1'b0, 5, "backpressure");
        fetch(32'h0000_0006, 32'h0000_0000, 1'b1, 0, "misaligned");
        fetch(32'h0000_0400, 32'h0000_0000, 1'b1, 0, "out_of_range");
        fetch(32'h0000_0008, 32'h00A0_0113, 1'b0, 1, "word2");

        prog(32'h0000_0400, 32'hBAD0_BAD0);
        fetch(32'h0000_0000, 32'h1111_1111, 1'b0, 0, "dropped_write");

        #1;
        req_valid = 1'b1;
        req_addr = 32'h0000_0004;
        @(posedge clk); #2;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_resp_data", resp_data, 0);
        chk("abort_resp_err", resp_err, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #2;
            chk("abort_no_resp", resp_valid, 0);
        end
        fetch(32'h0000_0004, 32'h0050_0093, 1'b0, 0, "after_reset");

        #1;
        req_valid = 1'b1;
        req_addr = 32'h0000_0004;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        prog_we = 1'b1;
        prog_addr = 32'h0000_0004;
        prog_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        prog_we = 1'b0;
        chk("collide_valid", resp_valid, 1);
        chk("collide_old_data", resp_data, 32'h0050_0093);
        resp_ready = 1'b1;
        @(posedge clk); #2;
        resp_ready = 1'b0;
        fetch(32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 0, "refetch");

        rise_cyc.delete();
        rise_data.delete();
        resp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (!req_ready && t < 40) begin
                @(posedge clk); #2;
                t++;
            end
            chk("seq_ready_wait", (t < 40), 1);
            req_addr = 32'(4 * i);
            @(posedge clk); #2;
        end
        req_valid = 1'b0;
        t = 0;
        while (rise_cyc.size() < 3 && t < 40) begin
            @(posedge clk); #2;
            t++;
        end
        chk("seq_count", rise_cyc.size(), 3);
        if (rise_cyc.size() == 3) begin
            chk("seq_data0", rise_data[0], 32'h1111_1111);
            chk("seq_data1", rise_data[1], 32'hDEAD_BEEF);
            chk("seq_data2", rise_data[2], 32'h00A0_0113);
            chk("seq_gap01", rise_cyc[1] - rise_cyc[0], LAT + 2);
            chk("seq_gap12", rise_cyc[2] - rise_cyc[1], LAT + 2);
        end
        resp_ready = 1'b0;
        @(posedge clk); #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
